// File: rtl/m10k_read_gather_pkg.sv
// m10k_pkg: FSM state encodings and tag layout shared by the M10K read and write paths.
package m10k_pkg;
    typedef enum logic [3:0] {
        IDLE  = 4'd15,
        ISSUE = 4'd1,
        WAIT  = 4'd2,
        DONE  = 4'd8
    } state_e;
    localparam int ROW_W = 3;
    localparam int TAG_W = ROW_W + 1;
endpackage

// File: rtl/m10k_read_gather_rd_valid_pipe.sv
// rd_valid_pipe: DEPTH-stage shift register carrying {valid, row} tags alongside the RAM read latency.
module rd_valid_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 4
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic [W-1:0] i_tag,
    output logic [W-1:0] o_tag
);
    logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d[0] = i_tag;
        for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) pipe_q <= '0;
        else         pipe_q <= pipe_d;
    end

    assign o_tag = pipe_q[DEPTH-1];
endmodule

// File: rtl/m10k_read_gather.sv
// m10k_read_gather: reads ROWS consecutive M10K words from OFFSET and gathers them into one wide matrix bus.
module m10k_read_gather
    import m10k_pkg::*;
#(
    parameter int DATA_LEN     = 32,
    parameter int N            = 8,
    parameter int ROWS         = 4,
    parameter int ADDRESS_SIZE = 4,
    parameter int OFFSET       = 12,
    parameter int RD_LATENCY   = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_read_start,
    input  logic [DATA_LEN*N-1:0]      i_read_data,
    output logic [ADDRESS_SIZE-1:0]    o_read_addr,
    output logic                       o_read_en,
    output logic [DATA_LEN*N*ROWS-1:0] o_out_mat,
    output logic [3:0]                 o_state,
    output logic                       o_busy,
    output logic                       o_done
);
    localparam int         W    = DATA_LEN * N;
    localparam logic [3:0] LAST = 4'(ROWS - 1);
    localparam logic [3:0] ALL  = 4'(ROWS);

    state_e             state_q, state_d;
    logic [3:0]         issue_cnt_q, issue_cnt_d, capture_cnt_q, capture_cnt_d;
    logic [TAG_W-1:0]   tag_in, tag_out;
    logic               cap;
    logic [ROW_W-1:0]   cap_row;

    assign tag_in         = {state_q == ISSUE, issue_cnt_q[ROW_W-1:0]};
    assign {cap, cap_row} = tag_out;

    rd_valid_pipe #(.DEPTH(RD_LATENCY), .W(TAG_W)) u_pipe (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_tag  (tag_in),
        .o_tag  (tag_out)
    );

    // WAIT looks at the post-capture count so DONE follows the last capture directly
    always_comb begin
        state_d       = state_q;
        issue_cnt_d   = issue_cnt_q;
        capture_cnt_d = capture_cnt_q + 4'(cap);
        case (state_q)
            IDLE: if (i_read_start) begin
                state_d       = ISSUE;
                issue_cnt_d   = '0;
                capture_cnt_d = '0;
            end
            ISSUE: begin
                issue_cnt_d = issue_cnt_q + 4'd1;
                if (issue_cnt_q == LAST) state_d = WAIT;
            end
            WAIT:    if (capture_cnt_d == ALL) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= IDLE;
            issue_cnt_q   <= '0;
            capture_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            capture_cnt_q <= capture_cnt_d;
        end
    end

    assign o_state     = state_q;
    assign o_busy      = state_q != IDLE;
    assign o_done      = state_q == DONE;
    assign o_read_en   = state_q == ISSUE;
    assign o_read_addr = o_read_en ? ADDRESS_SIZE'(OFFSET) + ADDRESS_SIZE'(issue_cnt_q) : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [W-1:0] row_q, row_d;
        always_comb row_d = (cap && cap_row == ROW_W'(r)) ? i_read_data : row_q;
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) row_q <= '0;
            else         row_q <= row_d;
        end
        assign o_out_mat[W*r +: W] = row_q;
    end
endmodule

// File: tb/tb_m10k_read_gather.sv
// tb_m10k_read_gather: scoreboarded random gathers over three offset/latency/row configurations.
module tb_m10k_read_gather;
    localparam int W = 256;

    logic clk = 1'b0;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_t
        localparam int OFF = (g == 0) ? 12 : (g == 1) ? 14 : 3;
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        localparam int RW  = (g == 0) ? 4 : (g == 1) ? 4 : 8;
        localparam int MW  = W * RW;

        logic          rstn, start, en, busy, done;
        logic [W-1:0]  rdata;
        logic [3:0]    addr, st;
        logic [MW-1:0] mat;
        logic [W-1:0]  mem [16];
        logic [W-1:0]  sh [LAT];
        logic [MW-1:0] exp_mat_q [$];
        int            exp_cyc_q [$];
        int            acyc_q [$];
        logic [3:0]    aval_q [$];
        logic [MW-1:0] hold = '0;
        int            ndone = 0;
        bit            fin = 1'b0;

        m10k_read_gather #(
            .DATA_LEN(32), .N(8), .ROWS(RW), .ADDRESS_SIZE(4), .OFFSET(OFF), .RD_LATENCY(LAT)
        ) dut (
            .i_clk        (clk),
            .i_rstn       (rstn),
            .i_read_start (start),
            .i_read_data  (rdata),
            .o_read_addr  (addr),
            .o_read_en    (en),
            .o_out_mat    (mat),
            .o_state      (st),
            .o_busy       (busy),
            .o_done       (done)
        );

        // RAM model: enabled reads appear LAT cycles later, otherwise garbage
        always @(posedge clk) begin
            sh[0] <= en ? mem[addr] : {8{$urandom}};
            for (int i = 1; i < LAT; i++) sh[i] <= sh[i-1];
        end
        assign rdata = sh[LAT-1];

        always @(negedge clk) begin
            if (!rstn) begin
                hold = '0;
                chk($sformatf("i%0d rst_state", g), 256'(st), 256'(15));
                chk($sformatf("i%0d rst_en", g), 256'(en), 256'(0));
                chk($sformatf("i%0d rst_addr", g), 256'(addr), 256'(0));
                chk($sformatf("i%0d rst_done", g), 256'(done), 256'(0));
                chk($sformatf("i%0d rst_busy", g), 256'(busy), 256'(0));
                for (int k = 0; k < RW; k++) chk($sformatf("i%0d rst_mat%0d", g, k), mat[W*k +: W], 256'(0));
            end else begin
                chk($sformatf("i%0d busy", g), 256'(busy), 256'(st != 4'd15));
                if (en) begin
                    chk($sformatf("i%0d addr_expected", g), 256'(acyc_q.size() != 0), 256'(1));
                    if (acyc_q.size() != 0) begin
                        chk($sformatf("i%0d addr_cycle", g), 256'(cyc), 256'(acyc_q.pop_front()));
                        chk($sformatf("i%0d addr", g), 256'(addr), 256'(aval_q.pop_front()));
                    end
                end
                if (done) begin
                    ndone++;
                    chk($sformatf("i%0d done_expected", g), 256'(exp_mat_q.size() != 0), 256'(1));
                    if (exp_mat_q.size() != 0) begin
                        hold = exp_mat_q.pop_front();
                        chk($sformatf("i%0d done_cycle", g), 256'(cyc), 256'(exp_cyc_q.pop_front()));
                        for (int k = 0; k < RW; k++) chk($sformatf("i%0d row%0d", g, k), mat[W*k +: W], hold[W*k +: W]);
                    end
                end else if (st == 4'd15) begin
                    for (int k = 0; k < RW; k++) chk($sformatf("i%0d idle_hold%0d", g, k), mat[W*k +: W], hold[W*k +: W]);
                end
            end
        end

        task automatic go();
            logic [MW-1:0] em;
            for (int a = 0; a < 16; a++)
                for (int j = 0; j < 8; j++) mem[a][32*j +: 32] = $urandom;
            for (int k = 0; k < RW; k++) begin
                em[W*k +: W] = mem[(OFF + k) % 16];
                acyc_q.push_back(cyc + 1 + k);
                aval_q.push_back(4'((OFF + k) % 16));
            end
            exp_mat_q.push_back(em);
            exp_cyc_q.push_back(cyc + 1 + RW + LAT);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        endtask

        task automatic wait_idle();
            int n = 0;
            while (exp_mat_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("i%0d timeout", g), 256'(n < 100), 256'(1));
            @(negedge clk);
        endtask

        initial begin
            int nd0;
            rstn  = 1'b0;
            start = 1'b0;
            for (int a = 0; a < 16; a++) mem[a] = '0;
            repeat (3) @(negedge clk);
            rstn = 1'b1;
            repeat (10) begin
                @(negedge clk);
                chk($sformatf("i%0d idle_state", g), 256'(st), 256'(15));
                chk($sformatf("i%0d idle_en", g), 256'(en), 256'(0));
                chk($sformatf("i%0d idle_done", g), 256'(done), 256'(0));
            end
            repeat (4) begin
                go();
                wait_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            // start held high throughout a transaction, then back-to-back launch
            nd0 = ndone;
            go();
            start = 1'b1;
            repeat (RW + LAT) @(negedge clk);
            @(negedge clk);
            chk($sformatf("i%0d busy_start_idle", g), 256'(st), 256'(15));
            chk($sformatf("i%0d busy_start_ndone", g), 256'(ndone), 256'(nd0 + 1));
            go();
            wait_idle();
            // reset mid-transaction
            go();
            repeat (3) @(negedge clk);
            @(posedge clk);
            #2 rstn = 1'b0;
            exp_mat_q.delete();
            exp_cyc_q.delete();
            acyc_q.delete();
            aval_q.delete();
            #1;
            chk($sformatf("i%0d abort_state", g), 256'(st), 256'(15));
            chk($sformatf("i%0d abort_en", g), 256'(en), 256'(0));
            chk($sformatf("i%0d abort_done", g), 256'(done), 256'(0));
            chk($sformatf("i%0d abort_mat0", g), mat[W-1:0], 256'(0));
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            @(negedge clk);
            go();
            wait_idle();
            chk($sformatf("i%0d addr_leftover", g), 256'(acyc_q.size()), 256'(0));
            fin = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (g_t[0].fin && g_t[1].fin && g_t[2].fin) break;
        end
        chk("all_finished", 256'({g_t[0].fin, g_t[1].fin, g_t[2].fin}), 256'(3'b111));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/m10k_read_gather.md
# m10k_read_gather

Sequential reader that pulls `ROWS` consecutive words from an M10K block RAM, starting at address `OFFSET`, and gathers them into one flat matrix vector. It sits on the read port of the same M10K that the accelerator's matrix write path fills. It returns a stored tile to the compute datapath as one wide bus, together with a one-cycle done pulse. The block accounts for the RAM's fixed read latency with a tagged valid pipeline.

## Interface
Parameters:
- `DATA_LEN`, 32, element width in bits
- `N`, 8, elements per RAM word (word width = `DATA_LEN*N`)
- `ROWS`, 4, words gathered per transaction (1..8)
- `ADDRESS_SIZE`, 4, RAM address width
- `OFFSET`, 12, first RAM address read
- `RD_LATENCY`, 2, cycles from address presented to data valid on `i_read_data` (1..3)

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge
- `i_rstn`  in  1  reset, asynchronous, active-low
- `i_read_start`  in  1  start request, sampled only in IDLE
- `i_read_data`  in  `DATA_LEN*N`  RAM read data
- `o_read_addr`  out  `ADDRESS_SIZE`  RAM read address
- `o_read_en`  out  1  RAM read enable
- `o_out_mat`  out  `DATA_LEN*N*ROWS`  gathered matrix; row k occupies `[DATA_LEN*N*k +: DATA_LEN*N]`
- `o_state`  out  4  current FSM state
- `o_busy`  out  1  high in any state other than IDLE
- `o_done`  out  1  one-cycle pulse; `o_out_mat` is complete while this is high

## Operation
- FSM states and encodings: IDLE=4'd15, ISSUE=4'd1, WAIT=4'd2, DONE=4'd8. Any other value goes to IDLE.
- IDLE: if `i_read_start`=1, go to ISSUE and clear the issue counter and capture counter. Otherwise stay in IDLE.
- ISSUE: drive `o_read_en`=1 and `o_read_addr`=(`OFFSET`+issue_cnt) mod 2^`ADDRESS_SIZE`. Wrap-around is intended and is not an error.
  - issue_cnt increments each cycle.
  - Enter a tag into the valid pipeline: valid=1, row=issue_cnt.
  - After issue_cnt=`ROWS`-1, go to WAIT.
- WAIT: `o_read_en`=0. Stay in WAIT until capture_cnt reaches `ROWS`, then go to DONE.
- Capture: when a tag exits the `RD_LATENCY`-deep pipeline with valid=1, register `i_read_data` into row slot `row` of `o_out_mat` and increment capture_cnt. Capture can happen in ISSUE or in WAIT.
- DONE: `o_done`=1 for exactly one cycle, then go to IDLE.
- `o_out_mat` holds its last gathered value until overwritten row by row in the next transaction. It is not cleared on start.
- `i_read_start` is ignored outside IDLE, including in DONE. No queuing.
- Outside ISSUE: `o_read_addr`=0, `o_read_en`=0.

## Timing
- Reset values: state=IDLE, `o_state`=4'd15, `o_out_mat`=0, `o_busy`=0, `o_done`=0, `o_read_en`=0, `o_read_addr`=0, valid pipeline all 0, both counters 0.
- `o_read_addr`, `o_read_en`, `o_done` and `o_busy` are decoded combinationally from state and counters. `o_out_mat` is registered.
- Cycle numbering: `i_read_start` is sampled at edge E0, so the first ISSUE cycle is cycle 1.
  - ISSUE occupies cycles 1..`ROWS`.
  - Row k data is valid in cycle 1+k+`RD_LATENCY` and is captured at the end of that cycle.
  - DONE occurs in cycle `ROWS`+`RD_LATENCY`+1.
  - Defaults (`ROWS`=4, `RD_LATENCY`=2): DONE in cycle 7; IDLE in cycle 8, where a new start can be sampled.
- Reset asserted mid-transaction: the FSM aborts to IDLE immediately and the pipeline is flushed. No partial DONE pulse is produced. `o_out_mat` returns to 0.
- `i_read_data` is ignored whenever no valid tag exits the pipeline.

## Structure
- Shared package `m10k_pkg`: state encodings (IDLE/ISSUE/WAIT/DONE). The M10K write path uses the same IDLE=4'd15 and DONE=4'd8 encodings, so `o_state` has the same meaning in both directions.
- Sub-module `rd_valid_pipe`: parameterised shift register with `RD_LATENCY` stages of {valid, row[2:0]}, with asynchronous reset. It is instantiated once.
- Top level contains the FSM, the counters, and the row-capture register bank, written with a generate loop per row.

## Test plan
- Reset then idle: hold `i_read_start`=0 for 10 cycles -> `o_state`=15, `o_read_en`=0, `o_out_mat`=0, no `o_done` pulse.
- Basic gather: RAM model with latency 2 and addr a holding {N{a}}; pulse start -> addresses 12,13,14,15 in cycles 1..4; `o_done` only in cycle 7; row k of `o_out_mat` = {N{12+k}}.
- Address wrap: `OFFSET`=14 -> addresses 14,15,0,1; rows hold the contents of 14,15,0,1.
- Latency sweep: `RD_LATENCY`=1 and 3 -> `o_done` in cycle 6 and cycle 8 respectively; data matches.
- Start while busy: assert `i_read_start` in cycles 2..7 -> no extra transaction; exactly one DONE; IDLE in cycle 8. A start sampled in cycle 8 launches the next read.
- Reset mid-read: drop `i_rstn` in cycle 5 -> all outputs at reset values immediately; no `o_done`; a fresh start after release completes normally.
